dual_issue_scheduler: RTL

In-order dual-issue scheduler between the two-slot `Decoder` and the execute lanes. It accepts one decoded instruction pair per handshake and holds it until issue. Each cycle it issues zero, one or two instructions in program order. Pairing is blocked by intra-pair dependencies, a shared memory port, control-flow instructions and a load-latency scoreboard.

---
 rtl/dual_issue_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: holds one decoded pair and issues 0/1/2
// instructions per cycle, gated by intra-pair hazards and a load scoreboard.
module dual_issue_scheduler #(
  parameter int WIDTH    = 32,
  parameter int RS       = 5,
  parameter int RD       = 5,
  parameter int LOAD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op_code_0,
  input  logic [4:0]       op_code_1,
  input  logic [3:0]       sub_op_code_0,
  input  logic [3:0]       sub_op_code_1,
  input  logic [RS-1:0]    rs1_0,
  input  logic [RS-1:0]    rs1_1,
  input  logic [RS-1:0]    rs2_0,
  input  logic [RS-1:0]    rs2_1,
  input  logic [RD-1:0]    rd_0,
  input  logic [RD-1:0]    rd_1,
  input  logic [WIDTH-1:0] imm_0,
  input  logic [WIDTH-1:0] imm_1,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             iss_valid_0,
  output logic             iss_valid_1,
  output logic [4:0]       iss_op_0,
  output logic [4:0]       iss_op_1,
  output logic [3:0]       iss_sub_0,
  output logic [3:0]       iss_sub_1,
  output logic [RS-1:0]    iss_rs1_0,
  output logic [RS-1:0]    iss_rs1_1,
  output logic [RS-1:0]    iss_rs2_0,
  output logic [RS-1:0]    iss_rs2_1,
  output logic [RD-1:0]    iss_rd_0,
  output logic [RD-1:0]    iss_rd_1,
  output logic [WIDTH-1:0] iss_imm_0,
  output logic [WIDTH-1:0] iss_imm_1
);

  typedef struct packed {
    logic [4:0]       op;
    logic [3:0]       sub;
    logic [RS-1:0]    rs1;
    logic [RS-1:0]    rs2;
    logic [RD-1:0]    rd;
    logic [WIDTH-1:0] imm;
  } inst_t;

  typedef enum logic [1:0] {S_EMPTY, S_PAIR, S_SECOND} state_t;

  state_t      state_q, state_d;
  inst_t       a_q, a_d, b_q, b_d;
  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];
  logic [31:0] busy;

  inst_t lane0, iss0, iss1;
  logic  ok0, ok1, fire0, fire1, done, accept;

  function automatic logic is_mem(input logic [4:0] op);
    return (op == 5'b00000) || (op == 5'b01000);
  endfunction

  function automatic logic is_ctrl(input logic [4:0] op);
    return (op == 5'b11000) || (op == 5'b11011) || (op == 5'b11001);
  endfunction

  function automatic logic sb_clear(input inst_t i, input logic [31:0] bv);
    return !bv[i.rs1] && !bv[i.rs2] && !bv[i.rd];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      busy[i] = (i != 0) && (cnt_q[i] != '0);
    end

    lane0 = (state_q == S_PAIR) ? a_q : b_q;
    ok0   = (state_q != S_EMPTY) && !flush && sb_clear(lane0, busy);
    ok1   = (state_q == S_PAIR) && ok0 && sb_clear(b_q, busy)
          && !((a_q.rd != '0) && ((a_q.rd == b_q.rs1) || (a_q.rd == b_q.rs2)
                                  || (a_q.rd == b_q.rd)))
          && !(is_mem(a_q.op) && is_mem(b_q.op))
          && !is_ctrl(a_q.op);
    fire0 = ok0 && ex_ready;
    fire1 = ok1 && ex_ready;

    done     = (state_q == S_PAIR) ? fire1 : fire0;
    in_ready = !flush && ((state_q == S_EMPTY) || done);
    accept   = in_valid && in_ready;

    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = S_PAIR;
    end else begin
      case (state_q)
        S_PAIR:   if (fire1) state_d = S_EMPTY; else if (fire0) state_d = S_SECOND;
        S_SECOND: if (fire0) state_d = S_EMPTY;
        default:  state_d = S_EMPTY;
      endcase
    end

    a_d = a_q;
    b_d = b_q;
    if (accept) begin
      a_d = '{op: op_code_0, sub: sub_op_code_0, rs1: rs1_0, rs2: rs2_0, rd: rd_0, imm: imm_0};
      b_d = '{op: op_code_1, sub: sub_op_code_1, rs1: rs1_1, rs2: rs2_1, rd: rd_1, imm: imm_1};
    end

    // Decrement first so a same-cycle load set overrides it.
    for (int unsigned i = 0; i < 32; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 3'd1 : cnt_q[i];
    end
    if (fire0 && (lane0.op == 5'b00000) && (lane0.rd != '0)) cnt_d[lane0.rd] = 3'(LOAD_LAT);
    if (fire1 && (b_q.op == 5'b00000) && (b_q.rd != '0))     cnt_d[b_q.rd]   = 3'(LOAD_LAT);

    iss0 = ok0 ? lane0 : '0;
    iss1 = ok1 ? b_q : '0;
  end

  assign iss_valid_0 = ok0;
  assign iss_valid_1 = ok1;
  assign iss_op_0    = iss0.op;
  assign iss_sub_0   = iss0.sub;
  assign iss_rs1_0   = iss0.rs1;
  assign iss_rs2_0   = iss0.rs2;
  assign iss_rd_0    = iss0.rd;
  assign iss_imm_0   = iss0.imm;
  assign iss_op_1    = iss1.op;
  assign iss_sub_1   = iss1.sub;
  assign iss_rs1_1   = iss1.rs1;
  assign iss_rs2_1   = iss1.rs2;
  assign iss_rd_1    = iss1.rd;
  assign iss_imm_1   = iss1.imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
